dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and load/store sequencer in front of the 16 KB four-bank data memory.
- Port m0 is the CPU load/store path. Port m1 is the debug/loader path.
- Grants one request per cycle, round-robin, and drives the memory's word address, write data and per-byte write enables.
- Returns a registered, lane-extracted and sign/zero-extended read response, or a write acknowledge, to the granted master.

Parameters:
- ADDR_W, 32, byte-address width of requester and memory address ports.
- MEM_WORDS, 4096, words per bank; any address with word index >= MEM_WORDS is an error.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset (sampled on posedge clk).
- mN_valid  in  1  request valid (N = 0, 1).
- mN_ready  out  1  request accepted this cycle.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  store data, right-aligned.
- mN_write  in  1  1 = store, 0 = load.
- mN_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mN_unsigned  in  1  load zero-extends when 1.
- mN_rsp_valid  out  1  one-cycle response pulse.
- mN_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- mN_rsp_err  out  1  misaligned, out-of-range or reserved size.
- daddr  out  32  to memory; the granted address.
- dwdata  out  32  to memory; lane-replicated store data.
- dwe  out  4  to memory; byte write enables, bit i = bank i.
- drdata  in  32  from memory; combinational read of word daddr[31:2].

Behaviour:
- Reset (reset high at posedge):
  - prio = 0 (m0 wins first tie).
  - All mN_rsp_valid, mN_rsp_err and mN_rsp_rdata = 0.
  - An in-flight response captured in the same cycle is discarded.
  - dwe is forced to 0 whenever reset is high, combinationally, so no write occurs during reset.
  - mN_ready = 0 while reset is high.
- Arbitration, combinational in cycle T:
  - If only one valid is high, that master is granted.
  - If both are high, the master indicated by prio is granted.
  - mN_ready = grant to N. At most one ready is high.
  - Masters must hold their request fields stable until ready.
- prio update: after a grant to master k, prio <= ~k. With no grant, prio holds.
- Memory drive during cycle T:
  - daddr = granted address.
  - With no grant: daddr = 0, dwdata = 0, dwe = 0.
- Error check, all combinational:
  - size 11 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr[ADDR_W-1:2] >= MEM_WORDS is an error.
  - Any error forces dwe = 0.
- Stores without error:
  - byte: dwe = 4'b0001 << addr[1:0]; dwdata = {4{wdata[7:0]}}.
  - half: dwe = addr[1] ? 1100 : 0011; dwdata = {2{wdata[15:0]}}.
  - word: dwe = 1111; dwdata = wdata.
  - The memory writes at the posedge ending cycle T.
- Loads:
  - dwe = 0.
  - Lane selection is applied to drdata sampled in cycle T.
  - byte: lane addr[1:0]. half: lanes addr[1] ? [31:16] : [15:0]. word: all lanes.
  - Result is sign-extended, or zero-extended if mN_unsigned = 1.
- Response:
  - Registered at the posedge ending T; mN_rsp_valid is high for exactly cycle T+1 (latency 1).
  - rsp_rdata and rsp_err are valid only while rsp_valid is high; otherwise 0.
  - There is no response backpressure; masters must accept the pulse.
  - Back-to-back grants give back-to-back responses, one per cycle. A response for m0 may coincide with a grant to m1.
- Read-after-write: a store granted at T followed by a load of the same word at T+1 returns the new data, because the memory updates at the T posedge.

Test Plan:
- After reset, m0 stores word 0xDEADBEEF to 0x10 and then loads 0x10. Required: dwe = 1111 at the store; m0_rsp_rdata = 0xDEADBEEF at the load's T+1; m0_rsp_err = 0.
- Byte/half extension: store byte 0x80 to 0x21, then:
  - load signed byte 0x21 -> 0xFFFFFF80.
  - load unsigned byte -> 0x00000080.
  - store half 0x8001 to 0x22, load signed half -> 0xFFFF8001.
  - Required dwe values: 0010 for the byte store, 1100 for the half store.
- Contention: m0 and m1 both valid for 4 cycles from reset. Required grant order m0, m1, m0, m1, with exactly one ready per cycle and each master's rsp_valid one cycle after its grant.
- Misaligned and illegal accesses, each -> dwe = 0, rsp_err = 1, rsp_rdata = 0, and memory unchanged on read-back:
  - word store to 0x06.
  - half load from 0x03.
  - size 11.
  - address 0x4000.
- Reset mid-operation: m1 store granted at T with reset asserted in T+1. Required: m1_rsp_valid stays 0 during and after reset; the store at T is committed; the first grant after reset goes to m0 when both are valid.
- Idle: no valids for 10 cycles. Required: dwe = 0, daddr = 0, no rsp_valid pulses, prio unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and load/store sequencer for the four-bank data memory.
// m0 is the CPU load/store path, m1 the debug/loader path. Requests are granted
// combinationally; responses are registered and pulse for one cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic              m0_write,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  output logic              m0_rsp_valid,
  output logic [31:0]       m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_write,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  output logic              m1_rsp_valid,
  output logic [31:0]       m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        dwe,
  input  logic [31:0]       drdata
);

  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] WORD_LIM = WIDX_W'(MEM_WORDS);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  logic              r_prio;
  logic [1:0]        r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_write;
  logic [1:0]        w_size;
  logic              w_uns;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_data;
  logic [31:0]       w_rsp_data;

  // Grant: lone requester wins, ties go to prio; nothing is granted during reset
  assign w_gnt0 = ~reset & m0_valid & (~m1_valid | ~r_prio);
  assign w_gnt1 = ~reset & m1_valid & (~m0_valid |  r_prio);
  assign w_any  = w_gnt0 | w_gnt1;

  assign m0_ready = w_gnt0;
  assign m1_ready = w_gnt1;

  // Request fields of the granted master
  assign w_addr  = w_gnt1 ? m1_addr     : m0_addr;
  assign w_wdata = w_gnt1 ? m1_wdata    : m0_wdata;
  assign w_write = w_gnt1 ? m1_write    : m0_write;
  assign w_size  = w_gnt1 ? m1_size     : m0_size;
  assign w_uns   = w_gnt1 ? m1_unsigned : m0_unsigned;

  // Reserved size, misalignment or word index beyond the memory
  assign w_err = (w_size == SZ_RSV)
               | ((w_size == SZ_HALF) & w_addr[0])
               | ((w_size == SZ_WORD) & (w_addr[1:0] != 2'b00))
               | (w_addr[ADDR_W-1:2] >= WORD_LIM);

  // Memory drive: address of the grant, lane-replicated store data and byte enables
  always_comb begin
    daddr  = '0;
    dwdata = '0;
    dwe    = 4'b0000;
    if (w_any) begin
      daddr = w_addr;
      if (w_write && !w_err) begin
        case (w_size)
          SZ_BYTE: begin
            dwe    = 4'b0001 << w_addr[1:0];
            dwdata = {4{w_wdata[7:0]}};
          end
          SZ_HALF: begin
            dwe    = w_addr[1] ? 4'b1100 : 4'b0011;
            dwdata = {2{w_wdata[15:0]}};
          end
          SZ_WORD: begin
            dwe    = 4'b1111;
            dwdata = w_wdata;
          end
          default: begin
            dwe    = 4'b0000;
            dwdata = '0;
          end
        endcase
      end
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    w_byte    = drdata[{w_addr[1:0], 3'b000} +: 8];
    w_half    = w_addr[1] ? drdata[31:16] : drdata[15:0];
    w_ld_data = '0;
    case (w_size)
      SZ_BYTE: w_ld_data = w_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_ld_data = w_uns ? {16'h0000, w_half}   : {{16{w_half[15]}}, w_half};
      SZ_WORD: w_ld_data = drdata;
      default: w_ld_data = '0;
    endcase
    w_rsp_data = (w_any && !w_write && !w_err) ? w_ld_data : 32'h0000_0000;
  end

  // Priority toggle and one-cycle response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_any) begin
        r_prio <= w_gnt0;
      end
      r_rsp_valid <= {w_gnt1, w_gnt0};
      r_rsp_rdata <= w_rsp_data;
      r_rsp_err   <= w_any & w_err;
    end
  end

  // Responses are suppressed while reset is held so nothing escapes mid-reset
  assign m0_rsp_valid = r_rsp_valid[0] & ~reset;
  assign m1_rsp_valid = r_rsp_valid[1] & ~reset;
  assign m0_rsp_rdata = m0_rsp_valid ? r_rsp_rdata : 32'h0000_0000;
  assign m1_rsp_rdata = m1_rsp_valid ? r_rsp_rdata : 32'h0000_0000;
  assign m0_rsp_err   = m0_rsp_valid & r_rsp_err;
  assign m1_rsp_err   = m1_rsp_valid & r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-level memory model, per-cycle compare, directed and random traffic.
module tb_dmem_arbiter;

  localparam int unsigned MEMW = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld, wr, uns;
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [1:0]  sz  [2];

  logic        m0_ready, m1_ready;
  logic        m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(rst),
    .m0_valid(vld[0]), .m0_ready(m0_ready), .m0_addr(adr[0]), .m0_wdata(wd[0]),
    .m0_write(wr[0]), .m0_size(sz[0]), .m0_unsigned(uns[0]),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_valid(vld[1]), .m1_ready(m1_ready), .m1_addr(adr[1]), .m1_wdata(wd[1]),
    .m1_write(wr[1]), .m1_size(sz[1]), .m1_unsigned(uns[1]),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  // Banked data memory seen by the DUT
  logic [31:0] ram [0:MEMW-1];
  assign drdata = ram[daddr[13:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dwe[b]) ram[daddr[13:2]][8*b +: 8] <= dwdata[8*b +: 8];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: byte-addressed memory, priority bit, pending response
  logic [7:0]  mm [0:4*MEMW-1];
  bit          m_prio = 1'b0;
  bit   [1:0]  e_rv = 2'b00;
  logic [31:0] e_rd = 32'h0;
  bit          e_re = 1'b0;

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || ((a / 4) >= MEMW);
  endfunction

  always @(negedge clk) begin : model
    int g, off, nb, base;
    logic [31:0] a, w, xdw, rd;
    logic [3:0] xdwe;
    bit err;
    bit rv0, rv1;
    g = -1;
    if (!rst) begin
      if (vld == 2'b11) g = int'(m_prio);
      else if (vld[0]) g = 0;
      else if (vld[1]) g = 1;
    end
    chk("m0_ready", m0_ready, g == 0);
    chk("m1_ready", m1_ready, g == 1);
    rv0 = !rst && e_rv[0];
    rv1 = !rst && e_rv[1];
    chk("m0_rsp_valid", m0_rsp_valid, rv0);
    chk("m1_rsp_valid", m1_rsp_valid, rv1);
    chk("m0_rsp_rdata", m0_rsp_rdata, rv0 ? e_rd : 32'h0);
    chk("m1_rsp_rdata", m1_rsp_rdata, rv1 ? e_rd : 32'h0);
    chk("m0_rsp_err", m0_rsp_err, rv0 && e_re);
    chk("m1_rsp_err", m1_rsp_err, rv1 && e_re);
    a = 0; w = 0; xdw = 0; xdwe = 0; rd = 0; err = 0; nb = 1; off = 0;
    if (g >= 0) begin
      a = adr[g]; w = wd[g]; err = is_err(a, sz[g]);
      nb = 1 << sz[g]; off = int'(a[1:0]);
      base = int'(a[13:0]);
      if (!err && wr[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (b >= off && b < off + nb) xdwe[b] = 1'b1;
          xdw[8*b +: 8] = w[8*(b % nb) +: 8];
        end
        for (int i = 0; i < nb; i++) mm[base + i] = w[8*i +: 8];
      end else if (!err) begin
        for (int i = 0; i < nb; i++) rd = rd | (32'(mm[base + i]) << (8 * i));
        if (!uns[g] && nb < 4 && rd[8*nb - 1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
      end
    end
    chk("daddr", daddr, a);
    chk("dwe", {28'h0, dwe}, {28'h0, xdwe});
    if (g < 0 || (wr[g] && !err)) chk("dwdata", dwdata, xdw);
    if (rst) begin
      e_rv = 2'b00; e_rd = 0; e_re = 0; m_prio = 0;
    end else begin
      e_rv = 2'b00;
      if (g >= 0) begin
        e_rv[g] = 1'b1;
        m_prio = (g == 0);
      end
      e_rd = rd;
      e_re = (g >= 0) && err;
    end
  end

  // One isolated request on master m, with literal expectations for grant cycle and response
  task automatic xact(input int m, input bit w, input logic [1:0] s, input bit u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] edwe, input logic [31:0] erd, input bit eerr);
    vld[m] = 1'b1; wr[m] = w; sz[m] = s; uns[m] = u; adr[m] = a; wd[m] = d;
    @(negedge clk);
    chk("x_ready", m ? m1_ready : m0_ready, 1);
    chk("x_dwe", {28'h0, dwe}, {28'h0, edwe});
    @(posedge clk); #1;
    vld[m] = 1'b0;
    @(negedge clk);
    chk("x_rsp_valid", m ? m1_rsp_valid : m0_rsp_valid, 1);
    chk("x_rsp_rdata", m ? m1_rsp_rdata : m0_rsp_rdata, erd);
    chk("x_rsp_err", m ? m1_rsp_err : m0_rsp_err, eerr);
    @(posedge clk); #1;
  endtask

  task automatic new_req(input int m);
    wr[m]  = 1'($urandom_range(0, 1));
    uns[m] = 1'($urandom_range(0, 1));
    sz[m]  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    adr[m] = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
    wd[m]  = $urandom;
  endtask

  initial begin
    logic [1:0] exp2, got;
    int pulses;
    for (int i = 0; i < int'(MEMW); i++) ram[i] = 32'h0;
    for (int i = 0; i < int'(4 * MEMW); i++) mm[i] = 8'h0;
    rst = 1'b1; vld = 2'b00; wr = 2'b00; uns = 2'b00;
    for (int m = 0; m < 2; m++) begin adr[m] = 0; wd[m] = 0; sz[m] = 0; end

    // Store presented during reset must not reach memory
    vld[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'd2; adr[0] = 32'h10; wd[0] = 32'h55;
    repeat (2) @(negedge clk);
    chk("rst_dwe", {28'h0, dwe}, 0);
    chk("rst_ready", {30'h0, m1_ready, m0_ready}, 0);
    chk("rst_rsp", {30'h0, m1_rsp_valid, m0_rsp_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0; vld = 2'b00;

    // Word, byte and half stores with loads and extension
    xact(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    xact(0, 1, 2'd0, 0, 32'h21, 32'h80, 4'b0010, 32'h0, 0);
    xact(0, 0, 2'd0, 0, 32'h21, 32'h0, 4'b0000, 32'hFFFFFF80, 0);
    xact(0, 0, 2'd0, 1, 32'h21, 32'h0, 4'b0000, 32'h00000080, 0);
    xact(0, 1, 2'd1, 0, 32'h22, 32'h8001, 4'b1100, 32'h0, 0);
    xact(0, 0, 2'd1, 0, 32'h22, 32'h0, 4'b0000, 32'hFFFF8001, 0);
    xact(1, 1, 2'd2, 0, 32'h4, 32'h11223344, 4'b1111, 32'h0, 0);

    // Illegal accesses followed by read-back of the affected word
    xact(1, 1, 2'd2, 0, 32'h6, 32'hAAAAAAAA, 4'b0000, 32'h0, 1);
    xact(1, 0, 2'd2, 0, 32'h4, 32'h0, 4'b0000, 32'h11223344, 0);
    xact(0, 0, 2'd1, 0, 32'h3, 32'h0, 4'b0000, 32'h0, 1);
    xact(0, 1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1);
    xact(0, 0, 2'd2, 0, 32'h20, 32'h0, 4'b0000, 32'h80018000, 0);
    xact(1, 1, 2'd2, 0, 32'h4000, 32'h12345678, 4'b0000, 32'h0, 1);
    xact(1, 0, 2'd2, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 0);

    // Contention straight out of reset
    rst = 1'b1;
    vld = 2'b11; wr = 2'b00; uns = 2'b00;
    sz[0] = 2'd2; adr[0] = 32'h10; sz[1] = 2'd2; adr[1] = 32'h20;
    @(negedge clk);
    chk("cont_rst_ready", {30'h0, m1_ready, m0_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp2 = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_ready", {30'h0, m1_ready, m0_ready}, {30'h0, exp2});
      if (k > 0) begin
        exp2 = (k % 2 == 1) ? 2'b01 : 2'b10;
        chk("cont_rsp", {30'h0, m1_rsp_valid, m0_rsp_valid}, {30'h0, exp2});
      end
      @(posedge clk); #1;
    end
    vld = 2'b00;
    @(negedge clk);
    chk("cont_rsp_last", {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h2);
    chk("cont_rdata_last", m1_rsp_rdata, 32'h80018000);
    @(posedge clk); #1;

    // Reset arriving the cycle after an m1 store
    vld[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'd2; adr[1] = 32'h30; wd[1] = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstmid_ready", m1_ready, 1);
    chk("rstmid_dwe", {28'h0, dwe}, 32'hF);
    @(posedge clk); #1;
    vld = 2'b00; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rsp_during", m1_rsp_valid, 0);
    @(posedge clk); #1;
    vld = 2'b11; wr = 2'b00; uns = 2'b00;
    sz[0] = 2'd2; adr[0] = 32'h30; sz[1] = 2'd2; adr[1] = 32'h30;
    @(negedge clk);
    chk("rstmid_rsp_during2", m1_rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_first_grant", {30'h0, m1_ready, m0_ready}, 32'h1);
    chk("rstmid_rsp_after", m1_rsp_valid, 0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_m0_rdata", m0_rsp_rdata, 32'hCAFEF00D);
    chk("rstmid_m1_ready", m1_ready, 1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_m1_rdata", m1_rsp_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Idle window
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_dwe", {28'h0, dwe}, 0);
      chk("idle_daddr", daddr, 0);
      if (m0_rsp_valid || m1_rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("idle_pulses", pulses, 0);
    vld = 2'b11;
    @(negedge clk);
    chk("idle_prio", {30'h0, m1_ready, m0_ready}, 32'h1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    vld = 2'b00;

    // Random traffic with held requests and occasional reset
    got = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!vld[m] || got[m]) begin
          if ($urandom_range(0, 2) != 0) begin
            vld[m] = 1'b1;
            new_req(m);
          end else begin
            vld[m] = 1'b0;
          end
        end
      end
      @(negedge clk);
      got = {m1_ready, m0_ready};
      @(posedge clk); #1;
    end
    rst = 1'b0; vld = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
